// File: rtl/ccm_pkg.sv
// Shared definitions for the colour-correction matrix stage: coefficient
// geometry, index names, default matrix and controller state encoding.
package ccm_pkg;

    localparam int COEF_W   = 12;
    localparam int NUM_COEF = 9;

    localparam logic [3:0] IDX_RR = 4'd0;
    localparam logic [3:0] IDX_RG = 4'd1;
    localparam logic [3:0] IDX_RB = 4'd2;
    localparam logic [3:0] IDX_GR = 4'd3;
    localparam logic [3:0] IDX_GG = 4'd4;
    localparam logic [3:0] IDX_GB = 4'd5;
    localparam logic [3:0] IDX_BR = 4'd6;
    localparam logic [3:0] IDX_BG = 4'd7;
    localparam logic [3:0] IDX_BB = 4'd8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        APPLY   = 2'd2
    } ccm_state_e;

    // Power-on matrix, x256 fixed point; each row sums to 256 (unity gain on grey).
    function automatic logic signed [COEF_W-1:0] ccm_default(input logic [3:0] idx);
        case (idx)
            IDX_RR:  return  12'sd398;
            IDX_RG:  return -12'sd30;
            IDX_RB:  return -12'sd112;
            IDX_GR:  return -12'sd58;
            IDX_GG:  return  12'sd388;
            IDX_GB:  return -12'sd74;
            IDX_BR:  return -12'sd25;
            IDX_BG:  return -12'sd112;
            IDX_BB:  return  12'sd393;
            default: return  12'sd0;
        endcase
    endfunction

    function automatic logic signed [COEF_W-1:0] ccm_identity(input logic [3:0] idx);
        case (idx)
            IDX_RR:  return 12'sd256;
            IDX_GG:  return 12'sd256;
            IDX_BB:  return 12'sd256;
            default: return 12'sd0;
        endcase
    endfunction

endpackage

// File: rtl/vsync_edge_det.sv
// Registers vsync and emits a one-cycle frame-start pulse on the edge
// selected by POL (1 = rising, 0 = falling).
module vsync_edge_det #(
    parameter bit POL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic vsync_in,
    output logic vsync_dly,
    output logic fs_pulse
);

    logic vsync_dly_q;
    logic vsync_dly_d;

    // Next value of the delayed vsync copy
    always_comb begin
        vsync_dly_d = vsync_in;
    end

    // Delayed vsync register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_dly_q <= 1'b0;
        end else begin
            vsync_dly_q <= vsync_dly_d;
        end
    end

    assign vsync_dly = vsync_dly_q;
    assign fs_pulse  = POL ? (vsync_in & ~vsync_dly_q) : (~vsync_in & vsync_dly_q);

endmodule

// File: rtl/ccm_coef_ctrl.sv
// Shadow/active coefficient controller for the 3x3 CCM; commits land on frame start.
// Optional identity bypass is enabled with `define CCM_COEF_IDENTITY_EN.
module ccm_coef_ctrl
    import ccm_pkg::*;
#(
    parameter bit VSYNC_POL = 1'b1
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         in_vsync,
    input  logic                         cfg_wr_en,
    input  logic [3:0]                   cfg_addr,
    input  logic [COEF_W-1:0]            cfg_wdata,
    input  logic                         cfg_commit,
    input  logic                         cfg_rd_active,
`ifdef CCM_COEF_IDENTITY_EN
    input  logic                         cfg_bypass,
`endif
    output logic [COEF_W-1:0]            cfg_rdata,
    output logic                         cfg_ready,
    output logic                         cfg_err,
    output logic [NUM_COEF*COEF_W-1:0]   coef_out,
    output logic                         coef_update
);

    localparam logic [3:0] NUM_COEF_A = 4'(NUM_COEF);

    ccm_state_e                  state_q, state_d;
    logic [COEF_W-1:0]           shadow_q [NUM_COEF];
    logic [COEF_W-1:0]           shadow_d [NUM_COEF];
    logic [COEF_W-1:0]           active_q [NUM_COEF];
    logic [COEF_W-1:0]           active_d [NUM_COEF];
    logic [NUM_COEF*COEF_W-1:0]  coef_q, coef_d;
    logic [COEF_W-1:0]           rdata_q, rdata_d;
    logic                        ready_q, ready_d;
    logic                        err_q, err_d;
    logic                        update_q, update_d;
    logic                        byp_stage_q, byp_stage_d;
    logic                        byp_q, byp_d;

    logic fs_s;
    logic vsync_dly_s;
    logic addr_ok_s;
    logic wr_ok_s;
    logic wr_bad_s;
    logic commit_ok_s;
    logic commit_bad_s;
    logic byp_chg_s;

    vsync_edge_det #(
        .POL(VSYNC_POL)
    ) u_fs_det (
        .clk      (clk),
        .rst_n    (reset_n),
        .vsync_in (in_vsync),
        .vsync_dly(vsync_dly_s),
        .fs_pulse (fs_s)
    );

    // Host strobe qualification; ready_q is high exactly when the FSM is IDLE
    always_comb begin
        addr_ok_s    = (cfg_addr < NUM_COEF_A);
        wr_ok_s      = cfg_wr_en & ready_q & addr_ok_s;
        wr_bad_s     = cfg_wr_en & ~(ready_q & addr_ok_s);
        commit_ok_s  = cfg_commit & ready_q;
        commit_bad_s = cfg_commit & ~ready_q;
    end

    // Commit sequencing, ready and sticky error next-state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (commit_ok_s) state_d = PENDING;
                else             state_d = IDLE;
            end
            PENDING: begin
                if (fs_s) state_d = APPLY;
                else      state_d = PENDING;
            end
            APPLY:   state_d = IDLE;
            default: state_d = IDLE;
        endcase

        ready_d = (state_d == IDLE);

        // A fresh error in the same cycle as an accepted commit stays visible
        if (wr_bad_s | commit_bad_s) begin
            err_d = 1'b1;
        end else if (commit_ok_s) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    // Bank updates and registered readback
    always_comb begin
        shadow_d = shadow_q;
        active_d = active_q;
        if (wr_ok_s) begin
            shadow_d[cfg_addr] = cfg_wdata;
        end else begin
            shadow_d = shadow_q;
        end
        if (state_q == APPLY) begin
            active_d = shadow_q;
        end else begin
            active_d = active_q;
        end

        if (!addr_ok_s) begin
            rdata_d = {COEF_W{1'b0}};
        end else if (cfg_rd_active) begin
            rdata_d = active_q[cfg_addr];
        end else begin
            rdata_d = shadow_q[cfg_addr];
        end
    end

    // Bypass staging: sampled at frame start, reaches the output one cycle later
    always_comb begin
`ifdef CCM_COEF_IDENTITY_EN
        if (fs_s) byp_stage_d = cfg_bypass;
        else      byp_stage_d = byp_stage_q;
`else
        byp_stage_d = 1'b0;
`endif
        byp_d     = byp_stage_q;
        byp_chg_s = byp_stage_q ^ byp_q;
        update_d  = (state_q == APPLY) | byp_chg_s;
    end

    // Output matrix follows the bank (or identity) that becomes current next cycle
    always_comb begin
        coef_d = coef_q;
        for (int k = 0; k < NUM_COEF; k++) begin
            if (byp_stage_q) begin
                coef_d[k*COEF_W +: COEF_W] = ccm_identity(4'(k));
            end else begin
                coef_d[k*COEF_W +: COEF_W] = active_d[k];
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            rdata_q     <= {COEF_W{1'b0}};
            ready_q     <= 1'b1;
            err_q       <= 1'b0;
            update_q    <= 1'b0;
            byp_stage_q <= 1'b0;
            byp_q       <= 1'b0;
            for (int k = 0; k < NUM_COEF; k++) begin
                shadow_q[k]                <= ccm_default(4'(k));
                active_q[k]                <= ccm_default(4'(k));
                coef_q[k*COEF_W +: COEF_W] <= ccm_default(4'(k));
            end
        end else begin
            state_q     <= state_d;
            rdata_q     <= rdata_d;
            ready_q     <= ready_d;
            err_q       <= err_d;
            update_q    <= update_d;
            byp_stage_q <= byp_stage_d;
            byp_q       <= byp_d;
            shadow_q    <= shadow_d;
            active_q    <= active_d;
            coef_q      <= coef_d;
        end
    end

    assign cfg_rdata   = rdata_q;
    assign cfg_ready   = ready_q;
    assign cfg_err     = err_q;
    assign coef_out    = coef_q;
    assign coef_update = update_q;

endmodule
